// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel output path.
package sobel_pkg;

    localparam int unsigned IMG_W_DEF  = 256;
    localparam int unsigned IMG_H_DEF  = 256;
    localparam int unsigned MAG_W_DEF  = 11;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StBorder   = 2'd1,
        StInterior = 2'd2,
        StDone     = 2'd3
    } state_e;

    localparam logic [7:0] BORDER_PIX = 8'h00;
    localparam logic [7:0] PIX_MAX    = 8'hFF;

endpackage

// File: rtl/sobel_pix_quant.sv
// Saturates a gradient magnitude to 8 bits and optionally binarises it.
module sobel_pix_quant
    import sobel_pkg::*;
#(
    parameter int unsigned MAG_W = MAG_W_DEF
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             bin_en,
    input  logic [7:0]       threshold,
    output logic [7:0]       pix
);

    logic [7:0] sat;

    always_comb begin
        sat = (mag > MAG_W'(255)) ? PIX_MAX : mag[7:0];
        if (bin_en) begin
            pix = (sat >= threshold) ? PIX_MAX : BORDER_PIX;
        end else begin
            pix = sat;
        end
    end

endmodule

// File: rtl/sobel_frame_writer.sv
// Writes one raster-order output frame: zero borders, quantised interior magnitudes.
module sobel_frame_writer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned MAG_W  = MAG_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bin_en,
    input  logic [7:0]        threshold,
    input  logic              in_valid,
    input  logic [MAG_W-1:0]  in_mag,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_W * IMG_H - 1);

    state_e            state_q;
    logic [ColW-1:0]   col_q, col_nxt;
    logic [RowW-1:0]   row_q, row_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              bin_en_q;
    logic [7:0]        threshold_q;
    logic [7:0]        pix;
    logic              nxt_border;

    sobel_pix_quant #(
        .MAG_W (MAG_W)
    ) u_quant (
        .mag       (in_mag),
        .bin_en    (bin_en_q),
        .threshold (threshold_q),
        .pix       (pix)
    );

    always_comb begin
        if (col_q == ColW'(IMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = row_q + 1'b1;
        end else begin
            col_nxt = col_q + 1'b1;
            row_nxt = row_q;
        end
        nxt_border = (row_nxt == '0) || (row_nxt == RowW'(IMG_H - 1)) ||
                     (col_nxt == '0) || (col_nxt == ColW'(IMG_W - 1));
    end

    assign in_ready = (state_q == StInterior);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            bin_en_q    <= 1'b0;
            threshold_q <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_en_q    <= bin_en;
                        threshold_q <= threshold;
                        row_q       <= '0;
                        col_q       <= '0;
                        addr_q      <= '0;
                        busy        <= 1'b1;
                        state_q     <= StBorder;
                    end
                end
                StBorder: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr_q;
                    wr_data <= BORDER_PIX;
                    col_q   <= col_nxt;
                    row_q   <= row_nxt;
                    addr_q  <= addr_q + 1'b1;
                    // Last pixel is always a border pixel, so completion is only seen here.
                    if (addr_q == LastAddr) begin
                        state_q <= StDone;
                    end else if (!nxt_border) begin
                        state_q <= StInterior;
                    end
                end
                StInterior: begin
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= pix;
                        col_q   <= col_nxt;
                        row_q   <= row_nxt;
                        addr_q  <= addr_q + 1'b1;
                        if (nxt_border) begin
                            state_q <= StBorder;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Scoreboard bench for sobel_frame_writer at 4x4 and 5x3 frame sizes.
module tb_sobel_frame_writer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int MW = 11;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, bin_en = 1'b0, in_valid = 1'b0;
    logic [7:0]    threshold = '0;
    logic [MW-1:0] in_mag = '0;
    logic          in_ready, wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic          start_b = 1'b0, bin_en_b = 1'b0, in_valid_b = 1'b0;
    logic [7:0]    threshold_b = '0;
    logic [MW-1:0] in_mag_b = '0;
    logic          in_ready_b, wr_en_b, busy_b, done_b;
    logic [AW-1:0] wr_addr_b;
    logic [7:0]    wr_data_b;

    always #5 clk = ~clk;

    sobel_frame_writer #(.IMG_W(W), .IMG_H(H), .MAG_W(MW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_en(bin_en), .threshold(threshold),
        .in_valid(in_valid), .in_mag(in_mag), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    sobel_frame_writer #(.IMG_W(5), .IMG_H(3), .MAG_W(MW), .ADDR_W(AW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin_en(bin_en_b),
        .threshold(threshold_b), .in_valid(in_valid_b), .in_mag(in_mag_b),
        .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] exp_qb[$];
    logic [AW+7:0] ea, eb;
    int n_writes = 0;
    int n_writes_b = 0;
    int mag_tab[4];
    int mag_b[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] qmodel(input int mag, input bit be, input logic [7:0] thr);
        logic [7:0] sat;
        sat = (mag > 255) ? 8'hFF : 8'(mag);
        if (be) return (sat >= thr) ? 8'hFF : 8'h00;
        return sat;
    endfunction

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", wr_addr, 32'hFFFF_FFFF);
            end else begin
                ea = exp_q.pop_front();
                check("wr_addr", wr_addr, ea[AW+7:8]);
                check("wr_data", wr_data, ea[7:0]);
            end
        end
        if (wr_en_b === 1'b1) begin
            n_writes_b++;
            if (exp_qb.size() == 0) begin
                check("b_unexpected_write", wr_addr_b, 32'hFFFF_FFFF);
            end else begin
                eb = exp_qb.pop_front();
                check("b_wr_addr", wr_addr_b, eb[AW+7:8]);
                check("b_wr_data", wr_data_b, eb[7:0]);
            end
        end
    end

    // stall: cycles of in_valid=0 at the first interior pixel; mid_start: cycle to pulse start
    task automatic run_frame(input bit be, input logic [7:0] thr, input int stall,
                             input int mid_start, input int abort_at, input int exp_cyc);
        int  idx, stalled, cyc;
        bit  xfer, fin, aborted;
        idx = 0; stalled = 0; cyc = 0; fin = 0; aborted = 0;
        n_writes = 0;
        for (int a = 0; a < W * H; a++) begin
            if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) begin
                exp_q.push_back({AW'(a), 8'h00});
            end else begin
                exp_q.push_back({AW'(a), qmodel(mag_tab[idx], be, thr)});
                idx++;
            end
        end
        idx = 0;
        bin_en = be; threshold = thr; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin) begin
            xfer = 0;
            if (done) begin
                check("done_cycle", cyc, exp_cyc);
                check("busy_at_done", busy, 0);
                check("write_count", n_writes, W * H);
                check("queue_drained", exp_q.size(), 0);
                fin = 1;
            end else if (cyc > 80) begin
                check("done_timeout", cyc, exp_cyc);
                fin = 1;
            end else if (abort_at > 0 && n_writes == abort_at) begin
                reset = 1'b0; in_valid = 1'b0; start = 1'b0;
                exp_q.delete();
                repeat (2) begin
                    @(negedge clk); #1;
                    check("abort_wr_en", wr_en, 0);
                    check("abort_busy", busy, 0);
                end
                check("abort_wr_addr", wr_addr, 0);
                reset = 1'b1;
                fin = 1; aborted = 1;
            end else begin
                start = (cyc == mid_start);
                if (start) threshold = ~thr;
                if (idx == 0 && in_ready && stalled < stall) begin
                    in_valid = 1'b0;
                    stalled++;
                end else begin
                    in_valid = (idx < 4);
                    in_mag = MW'(mag_tab[(idx < 4) ? idx : 0]);
                    xfer = in_valid && in_ready;
                end
                @(negedge clk); #1;
                cyc++;
                if (xfer) idx++;
            end
        end
        in_valid = 1'b0; start = 1'b0;
        if (!aborted) begin
            check("inputs_consumed", idx, 4);
            @(negedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int cyc, consumed;
        bit xfer;

        reset = 1'b0; start = 1'b1; start_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_b_busy", busy_b, 0);
        start = 1'b0; start_b = 1'b0; reset = 1'b1;
        @(negedge clk); #1;

        mag_tab = '{1, 2, 3, 4};
        run_frame(1'b0, 8'd0, 0, -1, 0, 17);
        mag_tab = '{300, 5, 6, 7};
        run_frame(1'b0, 8'd0, 0, -1, 0, 17);
        mag_tab = '{99, 100, 2047, 0};
        run_frame(1'b1, 8'd100, 0, -1, 0, 17);
        mag_tab = '{10, 20, 30, 40};
        run_frame(1'b0, 8'd0, 3, -1, 0, 20);
        mag_tab = '{11, 12, 13, 14};
        run_frame(1'b0, 8'd0, 0, -1, 7, 17);
        mag_tab = '{200, 50, 100, 99};
        run_frame(1'b1, 8'd100, 0, -1, 0, 17);
        mag_tab = '{150, 150, 150, 150};
        run_frame(1'b1, 8'd100, 0, 6, 0, 17);

        // 5x3 frame: interior is addresses 6..8
        mag_b = '{49, 50, 300};
        n_writes_b = 0;
        for (int a = 0; a < 15; a++) begin
            if (a >= 6 && a <= 8) exp_qb.push_back({AW'(a), qmodel(mag_b[a - 6], 1'b1, 8'd50)});
            else exp_qb.push_back({AW'(a), 8'h00});
        end
        bin_en_b = 1'b1; threshold_b = 8'd50; start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        cyc = 0; consumed = 0;
        while (!done_b && cyc < 60) begin
            start_b = (cyc == 2);
            if (start_b) threshold_b = 8'hFF;
            in_valid_b = (consumed < 3);
            in_mag_b = MW'(mag_b[(consumed < 3) ? consumed : 0]);
            xfer = in_valid_b && in_ready_b;
            @(negedge clk); #1;
            cyc++;
            if (xfer) consumed++;
        end
        in_valid_b = 1'b0; start_b = 1'b0;
        check("b_done_cycle", cyc, 16);
        check("b_write_count", n_writes_b, 15);
        check("b_inputs_consumed", consumed, 3);
        check("b_queue_drained", exp_qb.size(), 0);
        check("b_busy_at_done", busy_b, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
